// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared MMIO offsets, arbiter FSM states and address-region codes.
package mem_map_pkg;
  localparam logic [31:0] LED_OFS = 32'h0;
  localparam logic [31:0] SW_OFS = 32'h4;
  localparam logic [31:0] CYCLE_OFS = 32'h8;
  typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;
  typedef enum logic [2:0] {REG_RAM, REG_LED, REG_SW, REG_CYCLE, REG_NONE} region_t;
endpackage

// File: rtl/addr_decode.sv
// addr_decode: maps a byte address to a region and RAM word index; MMIO_EN=0 restricts it to RAM.
module addr_decode import mem_map_pkg::*; #(
  parameter int MEM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter bit MMIO_EN = 1'b1
) (
  input logic [31:0] addr,
  output region_t region,
  output logic [$clog2(MEM_WORDS)-1:0] word
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;
  localparam logic [31:0] LED_A = MMIO_BASE + LED_OFS;
  localparam logic [31:0] SW_A = MMIO_BASE + SW_OFS;
  localparam logic [31:0] CYC_A = MMIO_BASE + CYCLE_OFS;
  always_comb
    region = {1'b0, addr} < RAM_BYTES ? REG_RAM :
             !MMIO_EN ? REG_NONE :
             addr[31:2] == LED_A[31:2] ? REG_LED :
             addr[31:2] == SW_A[31:2] ? REG_SW :
             addr[31:2] == CYC_A[31:2] ? REG_CYCLE : REG_NONE;
  assign word = addr[AW+1:2];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM and a small MMIO block between
// the fetch and data ports, returning a one-cycle done pulse with held read data.
module mem_arbiter import mem_map_pkg::*; #(
  parameter int MEM_WORDS = 4096,
  parameter int RAM_LATENCY = 1,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input logic clk,
  input logic reset,
  input logic instr_req,
  input logic [31:0] instr_mem_addr,
  output logic [31:0] instr_mem_rd_data,
  output logic instr_done,
  input logic data_req,
  input logic [31:0] data_mem_addr,
  input logic [31:0] data_mem_wr_data,
  input logic data_mem_wr_en,
  output logic [31:0] data_mem_rd_data,
  output logic data_done,
  output logic bus_err,
  output logic ram_en,
  output logic ram_we,
  output logic [$clog2(MEM_WORDS)-1:0] ram_addr,
  output logic [31:0] ram_wr_data,
  input logic [31:0] ram_rd_data,
  input logic [15:0] sw_in,
  output logic [15:0] led_out
);
  localparam int AW = $clog2(MEM_WORDS);
  state_t state;
  region_t i_region, d_region, a_region;
  logic [AW-1:0] i_word, d_word;
  logic acc_d, acc_i, a_we, sel_d, cnt;
  logic [15:0] sw_s1, sw_s2;
  logic [31:0] cycle, mmio_rd;
  addr_decode #(.MEM_WORDS(MEM_WORDS), .MMIO_BASE(MMIO_BASE), .MMIO_EN(1'b0)) u_i_dec (
    .addr(instr_mem_addr), .region(i_region), .word(i_word));
  addr_decode #(.MEM_WORDS(MEM_WORDS), .MMIO_BASE(MMIO_BASE), .MMIO_EN(1'b1)) u_d_dec (
    .addr(data_mem_addr), .region(d_region), .word(d_word));
  assign acc_d = state == IDLE && data_req;
  assign acc_i = state == IDLE && !data_req && instr_req;
  assign a_region = acc_d ? d_region : i_region;
  assign a_we = acc_d && data_mem_wr_en;
  // RAM is strobed in the accept cycle itself; gating with reset keeps it quiet while held in reset
  assign ram_en = reset && (acc_d || acc_i) && a_region == REG_RAM;
  assign ram_we = ram_en && a_we;
  assign ram_addr = acc_d ? d_word : i_word;
  assign ram_wr_data = data_mem_wr_data;
  always_comb
    mmio_rd = d_region == REG_LED ? {16'h0, led_out} :
              d_region == REG_SW ? {16'h0, sw_s2} :
              d_region == REG_CYCLE ? cycle : 32'h0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cycle <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
    end
  // done/bus_err are set on entry to RESP so they are high exactly for the RESP cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sel_d <= 1'b0;
      cnt <= 1'b0;
      instr_done <= 1'b0;
      data_done <= 1'b0;
      bus_err <= 1'b0;
      instr_mem_rd_data <= '0;
      data_mem_rd_data <= '0;
      led_out <= '0;
    end else begin
      instr_done <= 1'b0;
      data_done <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: if (acc_d || acc_i) begin
          sel_d <= acc_d;
          if (a_region == REG_RAM && !a_we) begin
            state <= RAM_WAIT;
            cnt <= 1'(RAM_LATENCY - 1);
          end else begin
            state <= RESP;
            instr_done <= acc_i;
            data_done <= acc_d;
            bus_err <= a_region == REG_NONE;
            if (a_we && a_region == REG_LED) led_out <= data_mem_wr_data[15:0];
            if (acc_d && !a_we) data_mem_rd_data <= mmio_rd;
            if (acc_i) instr_mem_rd_data <= 32'h0;
          end
        end
        RAM_WAIT: if (!cnt) begin
          state <= RESP;
          instr_done <= !sel_d;
          data_done <= sel_d;
          if (sel_d) data_mem_rd_data <= ram_rd_data;
          else instr_mem_rd_data <= ram_rd_data;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the core's instruction and data memory ports; replaces two ideal memories with one shared single-port synchronous RAM plus a small MMIO region.
- Arbitrates instruction-fetch and data requests, sequences multi-cycle RAM latency, and returns a one-cycle done pulse with held read data.
- The multicycle controller waits on these done pulses before advancing.

Parameters:
- MEM_WORDS, 4096, RAM depth in 32-bit words; must be a power of 2.
- RAM_LATENCY, 1, RAM read latency in cycles; legal values 1 or 2.
- MMIO_BASE, 32'h8000_0000, base byte address of the MMIO region.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- instr_req  in  1  instruction fetch request (level, held until instr_done)
- instr_mem_addr  in  32  fetch byte address
- instr_mem_rd_data  out  32  fetched word; valid from instr_done until next fetch accept
- instr_done  out  1  one-cycle completion pulse
- data_req  in  1  data request (level, held until data_done)
- data_mem_addr  in  32  data byte address
- data_mem_wr_data  in  32  store word (already formatted by core)
- data_mem_wr_en  in  1  1 = store, 0 = load; sampled at accept
- data_mem_rd_data  out  32  load word; valid from data_done until next data accept
- data_done  out  1  one-cycle completion pulse
- bus_err  out  1  one-cycle pulse on unmapped access
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  $clog2(MEM_WORDS)  RAM word address
- ram_wr_data  out  32  RAM write data
- ram_rd_data  in  32  RAM read data (RAM_LATENCY cycles after ram_en)
- sw_in  in  16  board switches (asynchronous)
- led_out  out  16  LED register

Behaviour:
- Reset (reset = 0, async): state=IDLE; all done/err pulses=0; rd_data outputs=0; led_out=0; cycle counter=0; ram_en=ram_we=0; switch synchronizer=0.
- Address decode (addr[1:0] ignored, word aligned):
  - RAM when addr < MEM_WORDS*4.
  - LED at MMIO_BASE+0 (R/W, bits 15:0).
  - SW at MMIO_BASE+4 (RO, 2-flop synced, zero-extended).
  - CYCLE at MMIO_BASE+8 (RO, free-running 32-bit counter, wraps).
  - Anything else is unmapped. Instruction port decodes RAM only; MMIO fetch counts as unmapped.
- FSM states: IDLE, RAM_WAIT, RESP.
- IDLE:
  - If data_req, accept data; else if instr_req, accept instr. Data has fixed priority on simultaneous requests.
  - Latch port id, addr, wr_en, wr_data at accept.
  - RAM read: drive ram_en=1 that cycle; go to RAM_WAIT with a counter of RAM_LATENCY-1.
  - RAM write: ram_en=ram_we=1 that cycle; go to RESP.
  - MMIO / unmapped: perform register read/write that cycle; go to RESP.
- RAM_WAIT: count down; when ram_rd_data is valid, capture it into the selected port's rd_data; go to RESP.
- RESP:
  - Pulse the selected port's done (and bus_err if unmapped) for exactly one cycle; return to IDLE.
  - New accept is possible on the following cycle.
- Latency (accept cycle to done cycle):
  - RAM read: RAM_LATENCY+1 cycles.
  - RAM write, MMIO, unmapped: 1 cycle.
- Unmapped access: read returns 0; write dropped; bus_err pulses together with done.
- Writes to SW or CYCLE are dropped with no bus_err. LED writes take wr_data[15:0].
- Read data of the non-served port is held unchanged.
- Request dropped mid-transaction: the transaction still completes and done still pulses. The core must not deassert a request early; the bench checks it does not.
- Reset mid-transaction: abort immediately; no done pulse after reset release.
- Cycle counter increments every cycle, including during reset release, and wraps 0xFFFF_FFFF -> 0.

Decomposition:
- Shared package mem_map_pkg holds:
  - MMIO offset constants (LED_OFS=0, SW_OFS=4, CYCLE_OFS=8).
  - FSM state enum.
  - Region decode enum {REG_RAM, REG_LED, REG_SW, REG_CYCLE, REG_NONE}.
- One sub-module, addr_decode: combinational address -> region and RAM word index, instantiated once per port.

Test Plan:
- Fetch, RAM_LATENCY=1: instr_req with addr 0x10, RAM word 4 = 0x00500093 -> instr_done 2 cycles after accept, instr_mem_rd_data=0x00500093; ram_addr=4.
- Store then load: store 0xDEADBEEF to 0x20 -> data_done 1 cycle after accept, ram_we pulses at word 8; load 0x20 -> data_mem_rd_data=0xDEADBEEF.
- Simultaneous data_req (load 0x0) and instr_req (0x4) -> data served first; instr_done follows in a later cycle; rd_data of each port correct.
- MMIO: store 0x0000A5A5 to 0x80000000 -> led_out=0xA5A5; sw_in=0x1234 held 3 cycles, load 0x80000004 -> 0x00001234; two CYCLE reads N cycles apart differ by N.
- Unmapped: load 0x40000000 -> data_mem_rd_data=0, bus_err coincident with data_done; fetch at 0x80000000 -> bus_err, instr_mem_rd_data=0.
- Reset during RAM_WAIT with RAM_LATENCY=2 -> no done pulse afterward; led_out=0; next fetch completes normally.
